mux2_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 2:1 select path (sel=0 passes input A, sel=1 passes input B) between two requesters.
- It drives the select, forwards the granted requester's data into a one-entry registered output stage, and back-pressures with per-requester grants.
- A hold limit stops either requester from starving the other.
- It sits in front of the shared mux datapath and is the only block that drives its select.

---
 rtl/mux2_rr_arbiter.sv | 157 +++++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: two-requester round-robin arbiter that owns the select of a
// shared 2:1 mux. The granted requester's beat lands in a one-entry output
// register; MAX_HOLD bounds how long one side can keep the path while the
// other side waits.
//
// Handshake: every port pair is strict valid/ready. A beat moves when valid
// and ready are both high on a rising edge. Requester side: valid=req_x,
// ready=gnt_x. Downstream side: valid=out_valid, ready=out_ready. Grants
// never depend on req_x, so there is no combinational loop back to a requester.
module mux2_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             gnt_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    input  logic             out_ready,
    output logic             busy
);

    // Counter wide enough for MAX_HOLD-1, never narrower than one bit.
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_A = 2'd1,
        S_GRANT_B = 2'd2
    } state_e;

    // Complete arbiter state in one struct so checkers can bind to it directly.
    // last: 0 = A was granted most recently, 1 = B.
    typedef struct packed {
        state_e        state;
        logic          last;
        logic [CW-1:0] cnt;
    } arb_state_t;

    arb_state_t cur;
    arb_state_t nxt;

    logic free;
    logic acc_a;
    logic acc_b;

    // State register; reset leaves last=B so A wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur.state <= S_IDLE;
            cur.last  <= 1'b1;
            cur.cnt   <= '0;
        end else begin
            cur <= nxt;
        end
    end

    // Next-state: round-robin pick from IDLE, release on request drop, hand over at the hold limit.
    always_comb begin
        nxt = cur;
        case (cur.state)
            S_IDLE: begin
                if (req_a && (!req_b || cur.last)) begin
                    nxt.state = S_GRANT_A;
                    nxt.last  = 1'b0;
                    nxt.cnt   = '0;
                end else if (req_b) begin
                    nxt.state = S_GRANT_B;
                    nxt.last  = 1'b1;
                    nxt.cnt   = '0;
                end
            end
            S_GRANT_A: begin
                if (!req_a) begin
                    if (req_b) begin
                        nxt.state = S_GRANT_B;
                        nxt.last  = 1'b1;
                        nxt.cnt   = '0;
                    end else begin
                        nxt.state = S_IDLE;
                    end
                end else if (acc_a) begin
                    if (cur.cnt == CNT_LAST) begin
                        if (req_b) begin
                            nxt.state = S_GRANT_B;
                            nxt.last  = 1'b1;
                        end
                        nxt.cnt = '0;
                    end else begin
                        nxt.cnt = cur.cnt + CW'(1);
                    end
                end
            end
            S_GRANT_B: begin
                if (!req_b) begin
                    if (req_a) begin
                        nxt.state = S_GRANT_A;
                        nxt.last  = 1'b0;
                        nxt.cnt   = '0;
                    end else begin
                        nxt.state = S_IDLE;
                    end
                end else if (acc_b) begin
                    if (cur.cnt == CNT_LAST) begin
                        if (req_a) begin
                            nxt.state = S_GRANT_A;
                            nxt.last  = 1'b0;
                        end
                        nxt.cnt = '0;
                    end else begin
                        nxt.cnt = cur.cnt + CW'(1);
                    end
                end
            end
            default: begin
                nxt.state = S_IDLE;
            end
        endcase
    end

    // Outputs: grants come only from registered state and the output slot being free.
    always_comb begin
        free  = !out_valid || out_ready;
        gnt_a = (cur.state == S_GRANT_A) && free;
        gnt_b = (cur.state == S_GRANT_B) && free;
        acc_a = gnt_a && req_a;
        acc_b = gnt_b && req_b;
        busy  = (cur.state != S_IDLE);
    end

    // Output stage: load the accepted beat and its source, else drain on downstream ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 1'b0;
        end else if (acc_a) begin
            out_valid <= 1'b1;
            out_data  <= data_a;
            out_sel   <= 1'b0;
        end else if (acc_b) begin
            out_valid <= 1'b1;
            out_data  <= data_b;
            out_sel   <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Testbench for mux2_rr_arbiter: directed scenarios plus a random phase, with a
// cycle-level reference model feeding a scoreboard of expected output beats.
module tb_mux2_rr_arbiter;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    // ---------------- clock / reset ----------------
    logic             clk;
    logic             rst_n;
    logic             req_a;
    logic [WIDTH-1:0] data_a;
    logic             gnt_a;
    logic             req_b;
    logic [WIDTH-1:0] data_b;
    logic             gnt_b;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_sel;
    logic             out_ready;
    logic             busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux2_rr_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .data_a    (data_a),
        .gnt_a     (gnt_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .gnt_b     (gnt_b),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready),
        .busy      (busy)
    );

    // ---------------- scoreboard / model state ----------------
    logic [WIDTH:0]   exp_q[$];          // {sel, data}
    int               n_checks;
    int               n_errors;
    int               m_st;              // 0 idle, 1 grant A, 2 grant B
    logic             m_last;            // 0 = A, 1 = B
    int               m_cnt;
    logic             m_ov;
    logic             m_acc_a;
    logic             m_acc_b;
    logic             sel_log [0:63];
    logic [WIDTH-1:0] data_log [0:63];
    int               hs_count;
    logic [WIDTH-1:0] next_a;
    logic [WIDTH-1:0] next_b;
    logic [WIDTH-1:0] bp_exp [0:8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h80, 8'h81, 8'h82, 8'h83, 8'h04};
    logic             sw_lb, sw_ra, sw_rb, sw_ga, sw_gb;
    logic [WIDTH-1:0] sw_da, sw_db;
    logic [WIDTH-1:0] ed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_enter(input logic side);
        m_st   = side ? 2 : 1;
        m_last = side;
        m_cnt  = 0;
    endtask

    // Compare this cycle's DUT outputs against the model, then advance the model past the edge.
    task automatic model_step();
        logic           free, ea, eb, acc, side, mine, other;
        logic [WIDTH:0] head;
        free = !m_ov || out_ready;
        ea   = (m_st == 1) && free;
        eb   = (m_st == 2) && free;
        check("gnt_a", gnt_a, ea);
        check("gnt_b", gnt_b, eb);
        check("gnt_excl", gnt_a & gnt_b, 1'b0);
        check("busy", busy, m_st != 0);
        check("out_valid", out_valid, m_ov);
        if (m_ov && exp_q.size() > 0) begin
            head = exp_q[0];
            check("out_sel", out_sel, head[WIDTH]);
            check("out_data", out_data, head[WIDTH-1:0]);
            if (out_ready) begin
                if (hs_count < 64) begin
                    sel_log[hs_count]  = head[WIDTH];
                    data_log[hs_count] = head[WIDTH-1:0];
                end
                hs_count++;
                void'(exp_q.pop_front());
            end
        end
        m_acc_a = ea && req_a;
        m_acc_b = eb && req_b;
        acc     = m_acc_a || m_acc_b;
        if (m_acc_a) exp_q.push_back({1'b0, data_a});
        if (m_acc_b) exp_q.push_back({1'b1, data_b});
        if (acc) m_ov = 1'b1;
        else if (out_ready) m_ov = 1'b0;
        if (m_st == 0) begin
            if (req_a && req_b) model_enter(~m_last);
            else if (req_a) model_enter(1'b0);
            else if (req_b) model_enter(1'b1);
        end else begin
            side  = (m_st == 2);
            mine  = side ? req_b : req_a;
            other = side ? req_a : req_b;
            if (!mine) begin
                if (other) model_enter(~side);
                else m_st = 0;
            end else if (acc) begin
                if (m_cnt == MAX_HOLD - 1) begin
                    if (other) model_enter(~side);
                    else m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic ra, input logic [WIDTH-1:0] da,
                         input logic rb, input logic [WIDTH-1:0] db, input logic ordy);
        @(negedge clk);
        req_a     = ra;
        data_a    = da;
        req_b     = rb;
        data_b    = db;
        out_ready = ordy;
        #1;
        model_step();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        m_st     = 0; m_last = 1'b1; m_cnt = 0; m_ov = 1'b0;
        m_acc_a  = 1'b0; m_acc_b = 1'b0;
        exp_q.delete();
        hs_count = 0;
        next_a   = 8'h00;
        next_b   = 8'h80;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_sel", out_sel, 1'b0);
        check("rst_gnt", {gnt_a, gnt_b}, 2'b00);
        check("rst_busy", busy, 1'b0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0; out_ready = 1'b0;

        // Single requester: latency IDLE -> gnt -> out
        reset_dut();
        cycle(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1);
        check("single_c0_gnt_a", gnt_a, 1'b0);
        cycle(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1);
        check("single_c1_gnt_a", gnt_a, 1'b1);
        cycle(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1);
        check("single_c2_valid", out_valid, 1'b1);
        check("single_c2_data", out_data, 8'h3C);
        check("single_c2_sel", out_sel, 1'b0);
        check("single_c2_busy", busy, 1'b1);

        // Fair sharing: both requesting continuously
        reset_dut();
        for (int c = 0; c < 16; c++) begin
            cycle(1'b1, next_a, 1'b1, next_b, 1'b1);
            if (m_acc_a) next_a++;
            if (m_acc_b) next_b++;
        end
        check("fair_beats", hs_count, 14);
        for (int k = 0; k < 12; k++) begin
            ed = 8'((k / 8) * 4 + (k % 4));
            if (((k / 4) % 2) == 1) ed = ed + 8'h80;
            check("fair_sel", sel_log[k], (k / 4) % 2);
            check("fair_data", data_log[k], ed);
        end

        // Asynchronous reset mid-stream with a beat held
        check("async_pre_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", out_valid, 1'b0);
        check("async_gnt", {gnt_a, gnt_b}, 2'b00);
        check("async_busy", busy, 1'b0);

        // Backpressure during a B burst
        reset_dut();
        for (int c = 0; c < 20; c++) begin
            cycle(1'b1, next_a, 1'b1, next_b, !(c >= 6 && c <= 8));
            if (c >= 6 && c <= 8) begin
                check("bp_gnt_b", gnt_b, 1'b0);
                check("bp_hold_data", out_data, 8'h80);
                check("bp_hold_valid", out_valid, 1'b1);
            end
            if (m_acc_a) next_a++;
            if (m_acc_b) next_b++;
        end
        check("bp_beats", hs_count, 15);
        for (int k = 0; k < 9; k++) begin
            check("bp_data", data_log[k], bp_exp[k]);
            check("bp_sel", sel_log[k], (k >= 4 && k < 8) ? 1 : 0);
        end

        // Early release by A hands over to B at once; then A wins the next tie
        reset_dut();
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, next_a, 1'b1, next_b, 1'b1);
            if (m_acc_a) next_a++;
            if (m_acc_b) next_b++;
        end
        cycle(1'b0, next_a, 1'b1, next_b, 1'b1);
        cycle(1'b0, next_a, 1'b1, next_b, 1'b1);
        check("early_gnt_b", gnt_b, 1'b1);
        check("early_gnt_a", gnt_a, 1'b0);
        if (m_acc_b) next_b++;
        cycle(1'b0, next_a, 1'b1, next_b, 1'b1);
        if (m_acc_b) next_b++;
        cycle(1'b0, next_a, 1'b0, next_b, 1'b1);
        cycle(1'b1, next_a, 1'b1, next_b, 1'b1);
        check("early_idle_busy", busy, 1'b0);
        cycle(1'b1, next_a, 1'b1, next_b, 1'b1);
        check("early_tie_gnt_a", gnt_a, 1'b1);
        check("early_tie_gnt_b", gnt_b, 1'b0);

        // Mux equivalence sweep over {last, req_a, req_b} from IDLE
        for (int i = 0; i < 8; i++) begin
            sw_lb = i[2];
            sw_ra = i[1];
            sw_rb = i[0];
            sw_da = 8'(8'hA0 + i);
            sw_db = 8'(8'hB0 + i);
            reset_dut();
            if (!sw_lb) begin
                cycle(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
                cycle(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
                cycle(1'b0, 8'h11, 1'b0, 8'h00, 1'b1);
            end
            sw_ga = sw_ra && (!sw_rb || sw_lb);
            sw_gb = sw_rb && !sw_ga;
            cycle(sw_ra, sw_da, sw_rb, sw_db, 1'b1);
            check("sw_idle_gnt", {gnt_a, gnt_b}, 2'b00);
            cycle(sw_ra, sw_da, sw_rb, sw_db, 1'b1);
            check("sw_gnt_a", gnt_a, sw_ga);
            check("sw_gnt_b", gnt_b, sw_gb);
            cycle(1'b0, sw_da, 1'b0, sw_db, 1'b1);
            check("sw_valid", out_valid, sw_ga | sw_gb);
            if (sw_ga | sw_gb) begin
                check("sw_sel", out_sel, sw_gb);
                check("sw_data", out_data, sw_gb ? sw_db : sw_da);
            end
        end

        // Random traffic against the model, then drain
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 3) != 0, next_a, $urandom_range(0, 3) != 0, next_b,
                  $urandom_range(0, 4) != 0);
            if (m_acc_a) next_a = 8'($urandom_range(0, 255));
            if (m_acc_b) next_b = 8'($urandom_range(0, 255));
        end
        repeat (8) cycle(1'b0, next_a, 1'b0, next_b, 1'b1);
        check("sb_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
